// File: rtl/gate_timer_pkg.sv
// Shared types and constants for the gate_timer block.
package gate_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/gate_timer_tick_prescaler.sv
// Tick divider for gate_timer: tick is high once every presc+1 clk cycles.
module tick_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = (cnt == presc);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/gate_timer.sv
// One-shot / periodic gate timer with terminal-count clamp.
// Optional prescaler enabled by defining GATE_TIMER_PRESCALE_EN.
module gate_timer #(
    parameter int WIDTH    = 16,
    parameter int MAX_LOAD = 5000,
    parameter int PRESC_W  = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
`ifdef GATE_TIMER_PRESCALE_EN
    input  logic [PRESC_W-1:0] presc,
`endif
    output logic             busy,
    output logic             out,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    import gate_timer_pkg::*;

    localparam logic [WIDTH-1:0] MAX_TC = WIDTH'(MAX_LOAD);

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n, tc, tc_n, clamped, inc;
    logic             mode_r, mode_n, done_n;
    logic             accept, tick;

    assign clamped = (load_val > MAX_TC) ? MAX_TC : load_val;
    assign accept  = (state == IDLE) && start && !abort;
    assign inc     = count + WIDTH'(1);
    assign busy    = (state == RUN);
    assign out     = busy;

`ifdef GATE_TIMER_PRESCALE_EN
    logic [PRESC_W-1:0] presc_r;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc_r <= '0;
        end else if (accept) begin
            presc_r <= presc;
        end
    end

    // Held clear outside RUN so the first tick lands presc+1 cycles after start.
    tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .clr   (clr),
        .clear (accept || abort || (state != RUN)),
        .presc (presc_r),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_n = state;
        count_n = count;
        tc_n    = tc;
        mode_n  = mode_r;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    tc_n    = clamped;
                    mode_n  = mode;
                    count_n = '0;
                    if (clamped == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                // abort outranks a coincident terminal count
                if (abort) begin
                    state_n = IDLE;
                    count_n = '0;
                end else if (tick) begin
                    if (inc == tc) begin
                        done_n = 1'b1;
                        if (mode_r == MODE_PERIODIC) begin
                            count_n = '0;
                        end else begin
                            count_n = tc;
                            state_n = IDLE;
                        end
                    end else begin
                        count_n = inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            count  <= '0;
            tc     <= '0;
            mode_r <= MODE_ONESHOT;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            tc     <= tc_n;
            mode_r <= mode_n;
            done   <= done_n;
        end
    end

endmodule
